// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and widths for the branch resolve unit
package bp_pkg;
  localparam int BP_XLEN  = 32;
  localparam int BP_GHR   = 9;
  localparam int BP_PHT   = 9;
  localparam int BP_RAS   = 3;
  localparam int BP_DEPTH = 8;

  typedef struct packed {
    logic [BP_XLEN-1:0] pc;
    logic               pred_taken;
    logic               btb_hit;
    logic [BP_XLEN-1:0] pred_target;
    logic [BP_PHT-1:0]  pht_index;
    logic [BP_GHR-1:0]  prev_ghr;
    logic [BP_RAS-1:0]  sp_snap;
  } bq_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } brs_state_e;

  function automatic logic [BP_GHR-1:0] ghr_shift(input logic [BP_GHR-1:0] ghr,
                                                   input logic bit_in);
    return {ghr[BP_GHR-2:0], bit_in};
  endfunction
endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - PD enqueue, EX resolve and training strobe bundle
interface branch_resolve_unit_if;
  import bp_pkg::*;

  logic [1:0]         pd_valid;
  logic [BP_XLEN-1:0] pd_pc;
  logic [1:0]         pd_pred_taken;
  logic [1:0]         pd_btb_hit;
  logic [BP_XLEN-1:0] pd_pred_target1;
  logic [BP_XLEN-1:0] pd_pred_target2;
  logic [BP_PHT-1:0]  pd_pht_index1;
  logic [BP_PHT-1:0]  pd_pht_index2;
  logic [BP_GHR-1:0]  pd_prev_ghr;
  logic [BP_RAS-1:0]  pd_sp_snap;
  logic               pd_ready;

  logic               rs_valid;
  logic [BP_XLEN-1:0] rs_pc;
  logic [BP_XLEN-1:0] rs_target;
  logic               rs_taken;
  logic               rs_is_branch;
  logic               rs_is_ret;
  logic               rs_is_call;

  logic               mispredict;
  logic               restore_ghr;
  logic [BP_GHR-1:0]  ghr_snap;
  logic               actual_taken;
  logic               update_pht;
  logic [BP_PHT-1:0]  rb_pht_index;
  logic               update_btb;
  logic               ex_is_branch;
  logic               ex_is_ret;
  logic [BP_XLEN-1:0] ex_pc;
  logic [BP_XLEN-1:0] actual_target_address;
  logic               update_ras;
  logic [BP_XLEN-1:0] actual_return_address;
  logic               err_desync;

  modport master (
    output pd_valid, pd_pc, pd_pred_taken, pd_btb_hit, pd_pred_target1, pd_pred_target2,
           pd_pht_index1, pd_pht_index2, pd_prev_ghr, pd_sp_snap,
           rs_valid, rs_pc, rs_target, rs_taken, rs_is_branch, rs_is_ret, rs_is_call,
    input  pd_ready, mispredict, restore_ghr, ghr_snap, actual_taken, update_pht,
           rb_pht_index, update_btb, ex_is_branch, ex_is_ret, ex_pc, actual_target_address,
           update_ras, actual_return_address, err_desync
  );

  modport slave (
    input  pd_valid, pd_pc, pd_pred_taken, pd_btb_hit, pd_pred_target1, pd_pred_target2,
           pd_pht_index1, pd_pht_index2, pd_prev_ghr, pd_sp_snap,
           rs_valid, rs_pc, rs_target, rs_taken, rs_is_branch, rs_is_ret, rs_is_call,
    output pd_ready, mispredict, restore_ghr, ghr_snap, actual_taken, update_pht,
           rb_pht_index, update_btb, ex_is_branch, ex_is_ret, ex_pc, actual_target_address,
           update_ras, actual_return_address, err_desync
  );
endinterface

// File: rtl/branch_queue.sv
// rtl/branch_queue.sv - 2-write/1-read circular queue of predicted control-flow metadata
module branch_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [1:0]               push_n,
  input  bq_entry_t                push0,
  input  bq_entry_t                push1,
  input  logic                     pop,
  output bq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  bq_entry_t        mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; validity is tracked by the pointers and count only.
  always_ff @(posedge CLK) begin
    if (!clear) begin
      if (push_n != 2'd0) mem[wr_ptr] <= push0;
      if (push_n == 2'd2) mem[wr_ptr + AW'(1)] <= push1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push_n) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - matches EX resolutions to queued predictions and emits training strobes
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH
) (
  input  logic                  CLK,
  input  logic                  reset,
  branch_resolve_unit_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  brs_state_e state_q, state_d;
  bq_entry_t  slot0, slot1, push0, head;
  logic [1:0] push_n;
  logic [CW-1:0] q_count;
  logic       q_empty, q_clear, pop, ready;
  logic       desync, mis_d, tgt_diff;
  logic       unused_sp;

  // PD gives no per-slot branch type, so a valid slot0 is assumed to shift history for slot1.
  always_comb begin
    slot0 = '{pc: bus.pd_pc, pred_taken: bus.pd_pred_taken[0], btb_hit: bus.pd_btb_hit[0],
              pred_target: bus.pd_pred_target1, pht_index: bus.pd_pht_index1,
              prev_ghr: bus.pd_prev_ghr, sp_snap: bus.pd_sp_snap};
    slot1 = '{pc: bus.pd_pc + BP_XLEN'(4), pred_taken: bus.pd_pred_taken[1],
              btb_hit: bus.pd_btb_hit[1], pred_target: bus.pd_pred_target2,
              pht_index: bus.pd_pht_index2,
              prev_ghr: bus.pd_valid[0] ? ghr_shift(bus.pd_prev_ghr, bus.pd_pred_taken[0])
                                        : bus.pd_prev_ghr,
              sp_snap: bus.pd_sp_snap};
  end

  always_comb begin
    push_n = 2'd0;
    push0  = slot0;
    if (ready) begin
      push_n = {1'b0, bus.pd_valid[0]} + {1'b0, bus.pd_valid[1]};
      if (!bus.pd_valid[0]) push0 = slot1;
    end
  end

  assign pop      = bus.rs_valid && !q_empty;
  assign tgt_diff = (head.pred_target != bus.rs_target);
  assign desync   = bus.rs_valid && (q_empty || (bus.rs_pc != head.pc));
  assign mis_d    = bus.rs_valid &&
                    (desync || (head.pred_taken != bus.rs_taken) || (bus.rs_taken && tgt_diff));
  assign unused_sp = ^head.sp_snap;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // A mispredict clears the queue on its own edge, dropping any same-cycle enqueue.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    q_clear = mis_d;
    case (state_q)
      RUN: begin
        ready = (q_count <= CW'(DEPTH - 2));
        if (mis_d) state_d = FLUSH;
      end
      FLUSH: begin
        q_clear = 1'b1;
        state_d = mis_d ? FLUSH : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.pd_ready = ready;

  branch_queue #(.DEPTH(DEPTH)) u_queue (
    .CLK    (CLK),
    .reset  (reset),
    .clear  (q_clear),
    .push_n (push_n),
    .push0  (push0),
    .push1  (slot1),
    .pop    (pop),
    .head   (head),
    .count  (q_count),
    .empty  (q_empty)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      bus.mispredict            <= 1'b0;
      bus.restore_ghr           <= 1'b0;
      bus.ghr_snap              <= '0;
      bus.actual_taken          <= 1'b0;
      bus.update_pht            <= 1'b0;
      bus.rb_pht_index          <= '0;
      bus.update_btb            <= 1'b0;
      bus.ex_is_branch          <= 1'b0;
      bus.ex_is_ret             <= 1'b0;
      bus.ex_pc                 <= '0;
      bus.actual_target_address <= '0;
      bus.update_ras            <= 1'b0;
      bus.actual_return_address <= '0;
      bus.err_desync            <= 1'b0;
    end else begin
      bus.mispredict  <= mis_d;
      bus.restore_ghr <= mis_d;
      bus.update_pht  <= bus.rs_valid && !desync && bus.rs_is_branch;
      bus.update_btb  <= bus.rs_valid && !desync && bus.rs_taken && (!head.btb_hit || tgt_diff);
      bus.update_ras  <= bus.rs_valid && !desync && bus.rs_is_call;
      bus.err_desync  <= bus.err_desync || desync;
      if (bus.rs_valid) begin
        bus.actual_taken          <= bus.rs_taken;
        bus.rb_pht_index          <= head.pht_index;
        bus.ghr_snap              <= desync ? '0 :
                                     bus.rs_is_branch ? ghr_shift(head.prev_ghr, bus.rs_taken)
                                                      : head.prev_ghr;
        bus.ex_is_branch          <= bus.rs_is_branch;
        bus.ex_is_ret             <= bus.rs_is_ret;
        bus.ex_pc                 <= bus.rs_pc;
        bus.actual_target_address <= bus.rs_taken ? bus.rs_target : bus.rs_pc + BP_XLEN'(4);
        bus.actual_return_address <= bus.rs_pc + BP_XLEN'(4);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
  logic CLK = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  branch_resolve_unit_if bus ();
  branch_resolve_unit #(.DEPTH(8)) dut (.CLK(CLK), .reset(reset), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.pd_valid = 2'b00;      bus.pd_pc = '0;          bus.pd_pred_taken = 2'b00;
    bus.pd_btb_hit = 2'b00;    bus.pd_pred_target1 = '0; bus.pd_pred_target2 = '0;
    bus.pd_pht_index1 = '0;    bus.pd_pht_index2 = '0;  bus.pd_prev_ghr = '0;
    bus.pd_sp_snap = '0;
    bus.rs_valid = 1'b0;       bus.rs_pc = '0;          bus.rs_target = '0;
    bus.rs_taken = 1'b0;       bus.rs_is_branch = 1'b0; bus.rs_is_ret = 1'b0;
    bus.rs_is_call = 1'b0;
  endtask

  task automatic enq(input logic [1:0] v, input logic [31:0] pc, input logic [1:0] pt,
                     input logic [1:0] hit, input logic [31:0] t1, input logic [8:0] ph1,
                     input logic [8:0] ghr);
    bus.pd_valid = v;  bus.pd_pc = pc;  bus.pd_pred_taken = pt;  bus.pd_btb_hit = hit;
    bus.pd_pred_target1 = t1;  bus.pd_pred_target2 = t1;
    bus.pd_pht_index1 = ph1;   bus.pd_pht_index2 = ph1;  bus.pd_prev_ghr = ghr;
  endtask

  task automatic res(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                     input logic br, input logic call);
    bus.rs_valid = 1'b1;  bus.rs_pc = pc;  bus.rs_target = tgt;  bus.rs_taken = taken;
    bus.rs_is_branch = br;  bus.rs_is_ret = 1'b0;  bus.rs_is_call = call;
  endtask

  logic [31:0] q[$];
  logic [31:0] nextpc, dpc;
  logic        exp_rdy, do_deq;

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) tick();
    chk("rst_mispredict", bus.mispredict, 1'b0);
    chk("rst_err_desync", bus.err_desync, 1'b0);
    chk("rst_ghr_snap", bus.ghr_snap, 9'h0);
    chk("rst_count", dut.q_count, 4'd0);
    reset = 1'b0;
    tick();
    chk("rst_pd_ready", bus.pd_ready, 1'b1);

    // correct not-taken
    enq(2'b01, 32'h100, 2'b00, 2'b00, 32'h0, 9'h012, 9'h000);
    tick();  idle();
    chk("nt_count1", dut.q_count, 4'd1);
    res(32'h100, 32'h104, 1'b0, 1'b1, 1'b0);
    tick();  idle();
    chk("nt_mispredict", bus.mispredict, 1'b0);
    chk("nt_update_pht", bus.update_pht, 1'b1);
    chk("nt_update_btb", bus.update_btb, 1'b0);
    chk("nt_pht_index", bus.rb_pht_index, 9'h012);
    chk("nt_target", bus.actual_target_address, 32'h104);
    chk("nt_count0", dut.q_count, 4'd0);
    tick();
    chk("nt_pht_pulse", bus.update_pht, 1'b0);

    // direction mispredict
    enq(2'b01, 32'h180, 2'b00, 2'b00, 32'h0, 9'h033, 9'h0A5);
    tick();  idle();
    res(32'h180, 32'h200, 1'b1, 1'b1, 1'b0);
    tick();  idle();
    chk("dm_mispredict", bus.mispredict, 1'b1);
    chk("dm_restore_ghr", bus.restore_ghr, 1'b1);
    chk("dm_ghr_snap", bus.ghr_snap, 9'h14B);
    chk("dm_update_btb", bus.update_btb, 1'b1);
    chk("dm_target", bus.actual_target_address, 32'h200);
    chk("dm_flush_ready", bus.pd_ready, 1'b0);
    tick();
    chk("dm_mispredict_pulse", bus.mispredict, 1'b0);
    chk("dm_ready_back", bus.pd_ready, 1'b1);

    // target mismatch on a call
    enq(2'b01, 32'h300, 2'b01, 2'b01, 32'h400, 9'h005, 9'h011);
    tick();  idle();
    res(32'h300, 32'h480, 1'b1, 1'b0, 1'b1);
    tick();  idle();
    chk("tm_mispredict", bus.mispredict, 1'b1);
    chk("tm_update_btb", bus.update_btb, 1'b1);
    chk("tm_update_ras", bus.update_ras, 1'b1);
    chk("tm_ret_addr", bus.actual_return_address, 32'h304);
    chk("tm_update_pht", bus.update_pht, 1'b0);
    chk("tm_ghr_snap", bus.ghr_snap, 9'h011);
    tick();
    chk("tm_ras_pulse", bus.update_ras, 1'b0);

    // fill to 7 then wrap several times with interleaved dequeues
    nextpc = 32'h1000;
    enq(2'b01, nextpc, 2'b00, 2'b00, 32'h0, 9'h0, 9'h0);
    q.push_back(nextpc);  nextpc += 8;
    tick();
    for (int i = 0; i < 3; i++) begin
      enq(2'b11, nextpc, 2'b00, 2'b00, 32'h0, 9'h0, 9'h0);
      q.push_back(nextpc);  q.push_back(nextpc + 4);  nextpc += 8;
      tick();
    end
    chk("full_count7", dut.q_count, 4'd7);
    chk("full_not_ready", bus.pd_ready, 1'b0);
    enq(2'b11, 32'hDEAD0000, 2'b00, 2'b00, 32'h0, 9'h0, 9'h0);
    tick();
    chk("full_ignore", dut.q_count, 4'd7);
    for (int c = 0; c < 40; c++) begin
      exp_rdy = (q.size() <= 6);
      do_deq  = (c % 4 != 3) && (q.size() > 0);
      chk("wrap_ready", bus.pd_ready, exp_rdy);
      idle();
      enq(2'b11, nextpc, 2'b00, 2'b00, 32'h0, 9'h0, 9'h0);
      dpc = 32'h0;
      if (do_deq) begin
        dpc = q.pop_front();
        res(dpc, dpc + 4, 1'b0, 1'b1, 1'b0);
      end
      if (exp_rdy) begin
        q.push_back(nextpc);  q.push_back(nextpc + 4);
      end
      nextpc += 8;
      tick();
      if (do_deq) begin
        chk("wrap_mispredict", bus.mispredict, 1'b0);
        chk("wrap_order", bus.ex_pc, dpc);
      end
      chk("wrap_count", dut.q_count, q.size());
    end
    idle();
    for (int c = 0; c < 16 && q.size() > 0; c++) begin
      dpc = q.pop_front();
      res(dpc, dpc + 4, 1'b0, 1'b1, 1'b0);
      tick();
      chk("drain_mispredict", bus.mispredict, 1'b0);
      chk("drain_order", bus.ex_pc, dpc);
    end
    idle();
    chk("drain_empty", dut.q_count, 4'd0);

    // simultaneous enqueue and dequeue, then mispredict dropping enqueues
    enq(2'b01, 32'h5000, 2'b00, 2'b00, 32'h0, 9'h0, 9'h0);  tick();
    enq(2'b11, 32'h5010, 2'b00, 2'b00, 32'h0, 9'h0, 9'h0);  tick();
    enq(2'b11, 32'h5020, 2'b00, 2'b00, 32'h0, 9'h0, 9'h0);  tick();
    chk("sim_count5", dut.q_count, 4'd5);
    enq(2'b11, 32'h5030, 2'b00, 2'b00, 32'h0, 9'h0, 9'h0);
    res(32'h5000, 32'h5004, 1'b0, 1'b1, 1'b0);
    tick();
    chk("sim_count6", dut.q_count, 4'd6);
    chk("sim_no_mispredict", bus.mispredict, 1'b0);
    enq(2'b11, 32'h5040, 2'b00, 2'b00, 32'h0, 9'h0, 9'h0);
    res(32'h5010, 32'h6000, 1'b1, 1'b1, 1'b0);
    tick();
    chk("sim_mispredict", bus.mispredict, 1'b1);
    chk("sim_dropped", dut.q_count, 4'd0);
    chk("sim_flush_ready", bus.pd_ready, 1'b0);
    idle();
    enq(2'b11, 32'h5050, 2'b00, 2'b00, 32'h0, 9'h0, 9'h0);
    tick();
    idle();
    chk("sim_flush_ignore", dut.q_count, 4'd0);
    chk("sim_ready_back", bus.pd_ready, 1'b1);

    // resolve on empty queue
    res(32'h700, 32'h900, 1'b0, 1'b1, 1'b1);
    tick();  idle();
    chk("ds_err", bus.err_desync, 1'b1);
    chk("ds_mispredict", bus.mispredict, 1'b1);
    chk("ds_update_pht", bus.update_pht, 1'b0);
    chk("ds_update_ras", bus.update_ras, 1'b0);
    chk("ds_ghr_snap", bus.ghr_snap, 9'h000);
    tick();
    chk("ds_sticky", bus.err_desync, 1'b1);
    chk("ds_mispredict_pulse", bus.mispredict, 1'b0);

    // asynchronous reset mid-stream
    enq(2'b11, 32'h800, 2'b00, 2'b00, 32'h0, 9'h0, 9'h1FF);
    tick();  idle();
    chk("rm_count2", dut.q_count, 4'd2);
    res(32'h800, 32'h900, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rm_count0", dut.q_count, 4'd0);
    chk("rm_err_clear", bus.err_desync, 1'b0);
    chk("rm_mispredict", bus.mispredict, 1'b0);
    @(posedge CLK);
    #1;
    chk("rm_no_strobe", bus.mispredict, 1'b0);
    chk("rm_no_btb", bus.update_btb, 1'b0);
    reset = 1'b0;
    idle();
    tick();
    chk("rm_after_mispredict", bus.mispredict, 1'b0);
    chk("rm_after_count", dut.q_count, 4'd0);
    chk("rm_after_ready", bus.pd_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
